// File: rtl/cram_diag_loader.sv
// Writes one microword into a CRAM column through diag load functions 050..05(NFUNC-1),
// with optional readback compare over read functions 14x (build option CRAM_VERIFY_EN).
module cram_diag_loader #(
  parameter int NFUNC      = 4,
  parameter int DATA_W     = 36,
  parameter int ADR_W      = 11,
  parameter int STROBE_CYC = 2,
  parameter int READ_CYC   = 2
) (
  input  logic                    clk_crm_h,
  input  logic                    mr_reset_l,
  input  logic                    req_valid_h,
  output logic                    req_ready_h,
  input  logic [ADR_W-1:0]        req_adr_h,
  input  logic [NFUNC*DATA_W-1:0] req_data_h,
  input  logic                    req_verify_h,
  input  logic                    abort_h,
  output logic                    busy_h,
  output logic                    done_h,
  output logic                    err_h,
  output logic [2:0]              err_func_h,
  output logic [ADR_W-1:0]        cra_adr_h,
  output logic [2:0]              diag_func_h,
  output logic                    diag_load_func_05x_l,
  output logic                    diag_read_func_14x_l,
  output logic                    ebus_drv_h,
  output logic [DATA_W-1:0]       ebus_d_out_h,
  input  logic [DATA_W-1:0]       ebus_d_in_h
);

  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WSTROBE, S_WHOLD, S_RSETUP, S_RSTROBE, S_DONE
  } state_t;

  localparam logic [2:0] FI_LAST = 3'(NFUNC - 1);
  localparam logic [3:0] SC_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] RC_LAST = 4'(READ_CYC - 1);

  state_t                  state_q, state_d;
  logic [2:0]              fi_q, fi_d;
  logic [3:0]              cc_q, cc_d;
  logic [ADR_W-1:0]        adr_q;
  logic [NFUNC*DATA_W-1:0] data_q;
  logic [DATA_W-1:0]       cur_slice;
  logic                    accept;
  logic                    verify_en;

  assign accept    = (state_q == S_IDLE) && req_valid_h;
  assign cur_slice = data_q[int'(fi_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk_crm_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      state_q <= S_IDLE;
      fi_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      fi_q    <= fi_d;
      cc_q    <= cc_d;
    end
  end

  always_ff @(posedge clk_crm_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      adr_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      adr_q  <= req_adr_h;
      data_q <= req_data_h;
    end
  end

  always_comb begin
    state_d = state_q;
    fi_d    = fi_q;
    cc_d    = cc_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_h) begin
          state_d = S_WSETUP;
          fi_d    = '0;
        end
      end
      S_WSETUP: begin
        state_d = S_WSTROBE;
        cc_d    = '0;
      end
      S_WSTROBE: begin
        if (cc_q == SC_LAST) state_d = S_WHOLD;
        else                 cc_d    = cc_q + 4'd1;
      end
      S_WHOLD: begin
        if (fi_q != FI_LAST) begin
          fi_d    = fi_q + 3'd1;
          state_d = S_WSETUP;
        end else if (verify_en) begin
          fi_d    = '0;
          state_d = S_RSETUP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RSETUP: begin
        state_d = S_RSTROBE;
        cc_d    = '0;
      end
      S_RSTROBE: begin
        if (cc_q == RC_LAST) begin
          if (fi_q != FI_LAST) begin
            fi_d    = fi_q + 3'd1;
            state_d = S_RSETUP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cc_d = cc_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort beats any advance, including the final WHOLD/RSTROBE step.
    if (state_q != S_IDLE && abort_h) state_d = S_IDLE;
  end

  // Outputs decode the registered state only, so an async reset releases strobes at once.
  always_comb begin
    req_ready_h          = 1'b0;
    busy_h               = 1'b1;
    done_h               = 1'b0;
    cra_adr_h            = adr_q;
    diag_func_h          = '0;
    diag_load_func_05x_l = 1'b1;
    diag_read_func_14x_l = 1'b1;
    ebus_drv_h           = 1'b0;
    ebus_d_out_h         = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_h = 1'b1;
        busy_h      = 1'b0;
        cra_adr_h   = '0;
      end
      S_WSETUP, S_WHOLD: begin
        diag_func_h  = fi_q;
        ebus_drv_h   = 1'b1;
        ebus_d_out_h = cur_slice;
      end
      S_WSTROBE: begin
        diag_func_h          = fi_q;
        ebus_drv_h           = 1'b1;
        ebus_d_out_h         = cur_slice;
        diag_load_func_05x_l = 1'b0;
      end
      S_RSETUP: diag_func_h = fi_q;
      S_RSTROBE: begin
        diag_func_h          = fi_q;
        diag_read_func_14x_l = 1'b0;
      end
      S_DONE:  done_h = 1'b1;
      default: busy_h = 1'b1;
    endcase
  end

`ifdef CRAM_VERIFY_EN
  logic       verify_q;
  logic       err_q;
  logic [2:0] err_func_q;
  logic       rd_sample;

  assign verify_en = verify_q;
  assign rd_sample = (state_q == S_RSTROBE) && (cc_q == RC_LAST) && !abort_h;

  always_ff @(posedge clk_crm_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      verify_q   <= 1'b0;
      err_q      <= 1'b0;
      err_func_q <= '0;
    end else if (accept) begin
      verify_q   <= req_verify_h;
      err_q      <= 1'b0;
      err_func_q <= '0;
    end else if (rd_sample && !err_q && (ebus_d_in_h != cur_slice)) begin
      err_q      <= 1'b1;
      err_func_q <= fi_q;
    end
  end

  assign err_h      = err_q;
  assign err_func_h = err_func_q;
`else
  logic unused_in;
  assign unused_in  = ^{req_verify_h, ebus_d_in_h};
  assign verify_en  = 1'b0;
  assign err_h      = 1'b0;
  assign err_func_h = '0;
`endif

endmodule
